sensor_debounce: RTL and testbench

- Conditions the raw reed-switch inputs from the wheel fork and pedal crank before they reach the AHB sensor slave.
- Provides two independent, identical channels. Each channel has a 2-flop synchroniser, a stable-time qualifier, a minimum-active lockout and a saturating glitch counter.
- Outputs are clean active-low levels. They connect directly to the slave's nFork/nCrank inputs.
- Also provides one-cycle press strobes and glitch statistics for diagnostics.

---
 rtl/sensor_debounce.sv | 133 +++++++++++++
 tb/tb_sensor_debounce.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/sensor_debounce.sv
// Two-channel reed-switch conditioner: synchroniser, stable-time qualifier,
// minimum-active lockout and saturating glitch statistics per channel.
module sensor_debounce #(
    parameter int DEBOUNCE = 32,
    parameter int LOCKOUT  = 656,
    parameter int CNT_W    = 16
) (
    input  logic       HCLK,
    input  logic       HRESET,
    input  logic       nFork_raw,
    input  logic       nCrank_raw,
    input  logic       glitch_clear,
    output logic       nFork,
    output logic       nCrank,
    output logic       fork_press,
    output logic       crank_press,
    output logic [7:0] fork_glitches,
    output logic [7:0] crank_glitches
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        QUAL_LO = 2'd1,
        ACTIVE  = 2'd2,
        QUAL_HI = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE - 1);
    localparam logic [CNT_W-1:0] LOCK_MAX = CNT_W'(LOCKOUT);

    function automatic logic [7:0] sat_inc8(input logic [7:0] value);
        sat_inc8 = (value == 8'hFF) ? value : value + 8'd1;
    endfunction

    logic [1:0] raw_s;
    assign raw_s = {nCrank_raw, nFork_raw};

    for (genvar ch = 0; ch < 2; ch++) begin : g_ch
        logic             s1_r;
        logic             s2_r;
        state_t           state_r;
        logic [CNT_W-1:0] cnt_r;
        logic             out_r;
        logic             press_r;
        logic [7:0]       glitch_r;

        // Two-flop synchroniser; idles high so reset release shows no edge.
        always_ff @(posedge HCLK) begin
            if (HRESET) begin
                s1_r <= 1'b1;
                s2_r <= 1'b1;
            end else begin
                s1_r <= raw_s[ch];
                s2_r <= s1_r;
            end
        end

        // Qualification / lockout FSM with registered level, strobe and glitch count.
        always_ff @(posedge HCLK) begin
            if (HRESET) begin
                state_r  <= IDLE;
                cnt_r    <= CNT_ZERO;
                out_r    <= 1'b1;
                press_r  <= 1'b0;
                glitch_r <= 8'd0;
            end else begin
                press_r <= 1'b0;
                case (state_r)
                    IDLE: begin
                        if (!s2_r) begin
                            state_r <= QUAL_LO;
                            cnt_r   <= CNT_ONE;
                        end
                    end
                    QUAL_LO: begin
                        if (s2_r) begin
                            state_r <= IDLE;
                        end else if (cnt_r == DEB_LAST) begin
                            state_r <= ACTIVE;
                            out_r   <= 1'b0;
                            press_r <= 1'b1;
                            cnt_r   <= CNT_ZERO;
                        end else begin
                            cnt_r <= cnt_r + CNT_ONE;
                        end
                    end
                    ACTIVE: begin
                        // Release is only considered once the lockout has run out.
                        if (s2_r && (cnt_r >= LOCK_MAX)) begin
                            state_r <= QUAL_HI;
                            cnt_r   <= CNT_ONE;
                        end else if (cnt_r < LOCK_MAX) begin
                            cnt_r <= cnt_r + CNT_ONE;
                        end
                    end
                    QUAL_HI: begin
                        if (!s2_r) begin
                            state_r <= ACTIVE;
                            cnt_r   <= LOCK_MAX;
                        end else if (cnt_r == DEB_LAST) begin
                            state_r <= IDLE;
                            out_r   <= 1'b1;
                        end else begin
                            cnt_r <= cnt_r + CNT_ONE;
                        end
                    end
                    default: begin
                        state_r <= IDLE;
                        cnt_r   <= CNT_ZERO;
                        out_r   <= 1'b1;
                    end
                endcase

                // Clear takes priority over a coincident rejected excursion.
                if (glitch_clear) begin
                    glitch_r <= 8'd0;
                end else if ((state_r == QUAL_LO) && s2_r) begin
                    glitch_r <= sat_inc8(glitch_r);
                end
            end
        end
    end

    assign nFork          = g_ch[0].out_r;
    assign nCrank         = g_ch[1].out_r;
    assign fork_press     = g_ch[0].press_r;
    assign crank_press    = g_ch[1].press_r;
    assign fork_glitches  = g_ch[0].glitch_r;
    assign crank_glitches = g_ch[1].glitch_r;

endmodule

// File: tb/tb_sensor_debounce.sv
// Bench for sensor_debounce: directed scenarios plus random bouncing, all
// checked every cycle against a run-length reference model.
module tb_sensor_debounce;

    localparam int DEBOUNCE = 32;
    localparam int LOCKOUT  = 656;
    localparam int CNT_W    = 16;

    logic       HCLK = 1'b0;
    logic       HRESET = 1'b1;
    logic       nFork_raw = 1'b1;
    logic       nCrank_raw = 1'b1;
    logic       glitch_clear = 1'b0;
    logic       nFork;
    logic       nCrank;
    logic       fork_press;
    logic       crank_press;
    logic [7:0] fork_glitches;
    logic [7:0] crank_glitches;

    sensor_debounce #(.DEBOUNCE(DEBOUNCE), .LOCKOUT(LOCKOUT), .CNT_W(CNT_W)) dut (
        .HCLK(HCLK), .HRESET(HRESET), .nFork_raw(nFork_raw), .nCrank_raw(nCrank_raw),
        .glitch_clear(glitch_clear), .nFork(nFork), .nCrank(nCrank),
        .fork_press(fork_press), .crank_press(crank_press),
        .fork_glitches(fork_glitches), .crank_glitches(crank_glitches)
    );

    always #5 HCLK = ~HCLK;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int press_seen [2] = '{0, 0};

    // Reference model: raw delayed two samples, then run lengths of stable samples.
    logic m_s1 [2]    = '{1'b1, 1'b1};
    logic m_s2 [2]    = '{1'b1, 1'b1};
    logic m_out [2]   = '{1'b1, 1'b1};
    logic m_press [2] = '{1'b0, 1'b0};
    int   m_gl [2]    = '{0, 0};
    int   m_zrun [2]  = '{0, 0};
    int   m_since [2] = '{0, 0};
    int   m_orun [2]  = '{0, 0};

    task automatic model_step();
        logic raw [2];
        raw[0] = nFork_raw;
        raw[1] = nCrank_raw;
        for (int c = 0; c < 2; c++) begin
            logic s;
            bit   rejected;
            s = m_s2[c];
            rejected = 1'b0;
            if (HRESET) begin
                m_s1[c] = 1'b1; m_s2[c] = 1'b1; m_out[c] = 1'b1; m_press[c] = 1'b0;
                m_gl[c] = 0; m_zrun[c] = 0; m_since[c] = 0; m_orun[c] = 0;
            end else begin
                m_press[c] = 1'b0;
                if (m_out[c]) begin
                    // Output falls once DEBOUNCE consecutive low samples are seen.
                    if (!s) begin
                        m_zrun[c]++;
                        if (m_zrun[c] == DEBOUNCE) begin
                            m_out[c] = 1'b0; m_press[c] = 1'b1;
                            m_since[c] = 0; m_orun[c] = 0; m_zrun[c] = 0;
                        end
                    end else begin
                        if (m_zrun[c] > 0) rejected = 1'b1;
                        m_zrun[c] = 0;
                    end
                end else begin
                    // High samples only count once more than LOCKOUT edges follow the fall.
                    m_since[c]++;
                    if (s && (m_since[c] > LOCKOUT)) m_orun[c]++;
                    else m_orun[c] = 0;
                    if (m_orun[c] == DEBOUNCE) begin
                        m_out[c] = 1'b1; m_orun[c] = 0; m_zrun[c] = 0;
                    end
                end
                if (glitch_clear) m_gl[c] = 0;
                else if (rejected && (m_gl[c] < 255)) m_gl[c]++;
                m_s2[c] = m_s1[c];
                m_s1[c] = raw[c];
            end
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge HCLK);
        #1;
        cyc++;
        model_step();
        if (fork_press === 1'b1) press_seen[0]++;
        if (crank_press === 1'b1) press_seen[1]++;
        check("levels_strobes", {28'd0, nCrank, nFork, crank_press, fork_press},
              {28'd0, m_out[1], m_out[0], m_press[1], m_press[0]});
        check("fork_glitches", {24'd0, fork_glitches}, m_gl[0]);
        check("crank_glitches", {24'd0, crank_glitches}, m_gl[1]);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        int e0;
        int rem [2];

        // Reset state
        ticks(3);
        check("reset_levels", {nFork, nCrank, fork_press, crank_press}, 4'b1100);
        check("reset_glitches", {fork_glitches, crank_glitches}, 16'h0000);
        HRESET = 1'b0;
        ticks(5);

        // Clean press: low after edge E0+DEBOUNCE+1, one-cycle strobe
        nFork_raw = 1'b0;
        e0 = cyc + 1;
        while (cyc < e0 + DEBOUNCE) tick();
        check("clean_before_fall", {nFork, fork_press}, 2'b10);
        tick();
        check("clean_fall", {nFork, fork_press}, 2'b01);
        tick();
        check("clean_strobe_width", {31'd0, fork_press}, 32'd0);
        while (cyc < e0 + 999) tick();
        nFork_raw = 1'b1;
        e0 = cyc + 1;
        while (cyc < e0 + DEBOUNCE) tick();
        check("clean_before_rise", {31'd0, nFork}, 32'd0);
        tick();
        check("clean_rise", {31'd0, nFork}, 32'd1);
        check("clean_no_glitch", {24'd0, fork_glitches}, 32'd0);
        check("clean_one_press", press_seen[0], 32'd1);

        // Bounce rejection on crank
        nCrank_raw = 1'b0; ticks(20);
        nCrank_raw = 1'b1; ticks(5);
        nCrank_raw = 1'b0; ticks(20);
        nCrank_raw = 1'b1; ticks(40);
        check("bounce_glitches", {24'd0, crank_glitches}, 32'd2);
        check("bounce_no_press", press_seen[1], 32'd0);
        check("bounce_level", {31'd0, nCrank}, 32'd1);

        // Lockout: raw back high after 40 cycles, output held until lockout + qualification
        nFork_raw = 1'b0;
        e0 = cyc + 1;
        while (cyc < e0 + DEBOUNCE + 1) tick();
        check("lockout_fall", {nFork, fork_press}, 2'b01);
        while (cyc < e0 + 39) tick();
        nFork_raw = 1'b1;
        while (cyc < e0 + DEBOUNCE + 1 + LOCKOUT + DEBOUNCE - 1) tick();
        check("lockout_still_low", {31'd0, nFork}, 32'd0);
        tick();
        check("lockout_rise", {31'd0, nFork}, 32'd1);
        check("lockout_presses", press_seen[0], 32'd2);

        // Saturation, then clear coinciding with a further rejection
        repeat (300) begin
            nFork_raw = 1'b0; ticks(10);
            nFork_raw = 1'b1; ticks(5);
        end
        check("glitch_saturate", {24'd0, fork_glitches}, 32'd255);
        nFork_raw = 1'b0; ticks(10);
        nFork_raw = 1'b1; ticks(2);
        glitch_clear = 1'b1;
        tick();
        glitch_clear = 1'b0;
        check("clear_wins", {fork_glitches, crank_glitches}, 16'h0000);
        ticks(5);

        // Reset mid-qualification (fork) and mid-lockout (crank)
        nCrank_raw = 1'b0; ticks(10);
        nCrank_raw = 1'b1; ticks(5);
        check("pre_reset_glitch", {24'd0, crank_glitches}, 32'd1);
        nCrank_raw = 1'b0; ticks(40);
        nFork_raw = 1'b0; ticks(22);
        HRESET = 1'b1;
        tick();
        check("midreset_levels", {nFork, nCrank, fork_press, crank_press}, 4'b1100);
        check("midreset_glitches", {fork_glitches, crank_glitches}, 16'h0000);
        tick();
        HRESET = 1'b0;
        e0 = cyc + 1;
        while (cyc < e0 + DEBOUNCE) tick();
        check("requal_before", {nFork, nCrank}, 2'b11);
        tick();
        check("requal_fall", {nFork, nCrank, fork_press, crank_press}, 4'b0011);

        // Simultaneous channels
        nFork_raw = 1'b1; nCrank_raw = 1'b1;
        ticks(LOCKOUT + 2 * DEBOUNCE + 10);
        check("sim_idle", {nFork, nCrank}, 2'b11);
        nFork_raw = 1'b0; nCrank_raw = 1'b0;
        e0 = cyc + 1;
        while (cyc < e0 + DEBOUNCE + 1) tick();
        check("sim_fall", {nFork, nCrank, fork_press, crank_press}, 4'b0011);
        nFork_raw = 1'b1; nCrank_raw = 1'b1;
        ticks(LOCKOUT + 2 * DEBOUNCE + 10);

        // Random bouncing, occasional clears and resets
        rem[0] = 1; rem[1] = 1;
        for (int n = 0; n < 8000; n++) begin
            for (int c = 0; c < 2; c++) begin
                rem[c]--;
                if (rem[c] <= 0) begin
                    if (c == 0) nFork_raw = ~nFork_raw;
                    else nCrank_raw = ~nCrank_raw;
                    rem[c] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(50, 900))
                                                          : int'($urandom_range(1, 40));
                end
            end
            glitch_clear = ($urandom_range(0, 199) == 0);
            HRESET = ($urandom_range(0, 2999) == 0);
            tick();
        end
        HRESET = 1'b0;
        glitch_clear = 1'b0;
        ticks(2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
